// File: rtl/my_sync_fifo.sv
// Single-clock FIFO with registered read data and registered full/empty and
// almost-full/almost-empty flags derived from the next-cycle fill level.
module my_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int AF_MARGIN  = 1,
  parameter int AE_MARGIN  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_almost_full,
  output logic                  wr_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_almost_empty,
  output logic                  rd_empty
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LEVEL   = (ADDR_WIDTH + 1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_WIDTH:0] AE_LEVEL   = (ADDR_WIDTH + 1)'(AE_MARGIN);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  full_q, full_d;
  logic                  afull_q, afull_d;
  logic                  empty_q, empty_d;
  logic                  aempty_q, aempty_d;

  // Handshake: a write is taken on any edge where wr_en is high and wr_full is
  // low; a read is taken where rd_en is high and rd_empty is low, its word
  // appearing on rd_data after that edge. Refused requests have no effect.
  logic wr_accept;
  logic rd_accept;

  assign wr_accept = wr_en & ~full_q;
  assign rd_accept = rd_en & ~empty_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;

    if (wr_accept) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_accept) begin
      rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(1);
      rd_data_d = mem[rd_ptr_q];
    end

    unique case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
      default: count_d = count_q;
    endcase

    // Flags are computed from the next fill level so they track the edge that changes it.
    full_d   = (count_d == FULL_LEVEL);
    afull_d  = (count_d >= AF_LEVEL);
    empty_d  = (count_d == '0);
    aempty_d = (count_d <= AE_LEVEL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
      empty_q   <= 1'b1;
      aempty_q  <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
      empty_q   <= empty_d;
      aempty_q  <= aempty_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data         = rd_data_q;
  assign wr_full         = full_q;
  assign wr_almost_full  = afull_q;
  assign rd_empty        = empty_q;
  assign rd_almost_empty = aempty_q;

endmodule

// File: tb/tb_my_sync_fifo.sv
// Bench for my_sync_fifo: directed and random traffic checked every cycle
// against a queue-based model of the buffer contents.
module tb_my_sync_fifo;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          wr_almost_full;
  logic          wr_full;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_almost_empty;
  logic          rd_empty;

  my_sync_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_MARGIN (1),
    .AE_MARGIN (1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .wr_almost_full (wr_almost_full),
    .wr_full        (wr_full),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_almost_empty(rd_almost_empty),
    .rd_empty       (rd_empty)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_rd;
  int            tests_run;
  int            fail_count;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    int n;
    n = exp_q.size();
    check({tag, "_rd_data"},   rd_data,                   exp_rd);
    check({tag, "_empty"},     DW'(rd_empty),             DW'(n == 0));
    check({tag, "_aempty"},    DW'(rd_almost_empty),      DW'(n <= 1));
    check({tag, "_full"},      DW'(wr_full),              DW'(n == DEPTH));
    check({tag, "_afull"},     DW'(wr_almost_full),       DW'(n >= DEPTH - 1));
  endtask

  // driver: called at a falling edge, drives one cycle, checks at the next falling edge
  task automatic step(input string tag, input logic we, input logic re, input logic [DW-1:0] d);
    int  n;
    logic wr_ok;
    logic rd_ok;
    wr_en   = we;
    rd_en   = re;
    wr_data = d;
    @(posedge clk);
    n     = exp_q.size();
    wr_ok = we && (n < DEPTH);
    rd_ok = re && (n > 0);
    if (rd_ok) exp_rd = exp_q.pop_front();
    if (wr_ok) exp_q.push_back(d);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    exp_q.delete();
    exp_rd = '0;
    #50;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag, input int extra);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n + extra; i++) step(tag, 1'b0, 1'b1, $urandom);
  endtask

  initial begin
    tests_run  = 0;
    fail_count = 0;
    exp_rd     = '0;
    rst_n      = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    wr_data    = '0;

    do_reset();

    // fill 0..255, then one extra write that must be dropped
    for (int i = 0; i <= DEPTH; i++) step("fill", 1'b1, 1'b0, DW'(i));

    // read+write while full: read proceeds, write dropped
    step("rdwr_full", 1'b1, 1'b1, 32'hDEAD_BEEF);

    // drain the rest, plus reads on empty that must leave rd_data unchanged
    drain("drain", 3);

    // gapped write stream
    for (int i = 0; i < 12; i++) begin
      if (i == 6) step("gap", 1'b0, 1'b0, 32'hFFFF_FFFF);
      else        step("gap", 1'b1, 1'b0, DW'(32'h100 + i));
    end
    drain("gap_drain", 1);

    // write into empty with simultaneous read: write only
    step("rdwr_empty", 1'b1, 1'b1, 32'h0000_5A5A);

    // concurrent read/write holding fill level at 10
    while (exp_q.size() < 10) step("conc_fill", 1'b1, 1'b0, $urandom);
    for (int i = 0; i < 20; i++) step("conc", 1'b1, 1'b1, $urandom);
    check("conc_level", DW'(exp_q.size()), DW'(10));
    drain("conc_drain", 1);

    // random traffic with phases biased toward filling and toward draining
    for (int i = 0; i < 3000; i++) begin
      int wp;
      wp = ((i / 500) % 2 == 0) ? 80 : 25;
      step("rand", ($urandom_range(99) < wp), ($urandom_range(99) < 50), $urandom);
    end

    // reset mid-stream, then a single word must come back
    while (exp_q.size() < 5) step("pre_rst", 1'b1, 1'b0, $urandom);
    step("pre_rst", 1'b1, 1'b0, $urandom);
    do_reset();
    step("post_rst_wr", 1'b1, 1'b0, 32'hCAFE_0001);
    step("post_rst_rd", 1'b0, 1'b1, 32'h0);
    step("post_rst_idle", 1'b0, 1'b1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
